// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm
// Description : Miss-sequencing controller for a direct-mapped cache in front
//               of a four-banked main memory. On a miss it latches the CPU
//               request, optionally writes back the dirty victim line (WB0-3),
//               refills the line (RD0-3, FILL2-3), updates tag/data (UPD) and
//               signals completion (DONE). It also forms the memory address for
//               each burst beat and keeps a saturating miss counter.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               rd, wr, addr,
//               data_in            - CPU request (sampled only in IDLE)
//               hit, valid, dirty,
//               tag_out            - lookup result for the indexed line
//               mem_stall          - freezes the burst states
//               state              - 4-bit controller state code
//               req_addr/req_data/
//               req_wr             - latched request
//               mem_addr           - main-memory address
//               err                - rd and wr together while IDLE
//               miss_count         - saturating miss counter
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm #(
    parameter int MISS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [15:0]           addr,
    input  logic [15:0]           data_in,
    input  logic                  hit,
    input  logic                  valid,
    input  logic                  dirty,
    input  logic [4:0]            tag_out,
    input  logic                  mem_stall,
    output logic [3:0]            state,
    output logic [15:0]           req_addr,
    output logic [15:0]           req_data,
    output logic                  req_wr,
    output logic [15:0]           mem_addr,
    output logic                  err,
    output logic [MISS_CNT_W-1:0] miss_count
);

    localparam logic [3:0] S_IDLE  = 4'b0000;
    localparam logic [3:0] S_WB0   = 4'b0001;
    localparam logic [3:0] S_WB1   = 4'b0010;
    localparam logic [3:0] S_WB2   = 4'b0011;
    localparam logic [3:0] S_WB3   = 4'b0100;
    localparam logic [3:0] S_RD0   = 4'b0101;
    localparam logic [3:0] S_RD1   = 4'b0110;
    localparam logic [3:0] S_RD2   = 4'b0111;
    localparam logic [3:0] S_RD3   = 4'b1000;
    localparam logic [3:0] S_FILL2 = 4'b1001;
    localparam logic [3:0] S_FILL3 = 4'b1010;
    localparam logic [3:0] S_UPD   = 4'b1011;
    localparam logic [3:0] S_DONE  = 4'b1100;

    logic [3:0]            state_q, state_d;
    logic [15:0]           req_addr_q;
    logic [15:0]           req_data_q;
    logic                  req_wr_q;
    logic [4:0]            victim_q;
    logic [MISS_CNT_W-1:0] miss_count_q;

    logic                  w_idle;
    logic                  w_miss;
    logic [1:0]            w_word;

    assign w_idle = (state_q == S_IDLE);
    // Exactly one of rd/wr, and the lookup did not hit a valid line.
    assign w_miss = w_idle & (rd ^ wr) & ~(hit & valid);

    // Burst states WB0..FILL3 advance by one code per unstalled cycle, which
    // also carries WB3 into RD0 and FILL3 into UPD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_miss) begin
                    state_d = (valid & dirty) ? S_WB0 : S_RD0;
                end
            end
            S_WB0, S_WB1, S_WB2, S_WB3,
            S_RD0, S_RD1, S_RD2, S_RD3,
            S_FILL2, S_FILL3: begin
                if (!mem_stall) begin
                    state_d = state_q + 4'd1;
                end
            end
            S_UPD:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_wr_q     <= 1'b0;
            victim_q     <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_miss) begin
                req_addr_q <= addr;
                req_data_q <= data_in;
                req_wr_q   <= wr;
                victim_q   <= tag_out;
                if (miss_count_q != '1) begin
                    miss_count_q <= miss_count_q + MISS_CNT_W'(1);
                end
            end
        end
    end

    // Word index within the burst: WB0..WB3 are codes 1..4 and RD0..RD3 are
    // codes 5..8, so (code - 1) mod 4 gives the beat number for both.
    assign w_word = state_q[1:0] - 2'd1;

    always_comb begin
        mem_addr = req_addr_q;
        case (state_q)
            S_WB0, S_WB1, S_WB2, S_WB3:
                mem_addr = {victim_q, req_addr_q[10:3], w_word, 1'b0};
            S_RD0, S_RD1, S_RD2, S_RD3:
                mem_addr = {req_addr_q[15:3], w_word, 1'b0};
            default:
                mem_addr = req_addr_q;
        endcase
    end

    assign err        = rd & wr & w_idle;
    assign state      = state_q;
    assign req_addr   = req_addr_q;
    assign req_data   = req_data_q;
    assign req_wr     = req_wr_q;
    assign miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_fsm
// Description : Self-checking bench for cache_ctrl_fsm. Two instances share
//               stimulus: one with the default 16-bit miss counter and one
//               with a 2-bit counter for saturation. Each stimulus cycle
//               pushes its hand-computed expected outputs into a queue; a
//               monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        rd, wr, hit, valid, dirty, mem_stall;
    logic [15:0] addr, data_in;
    logic [4:0]  tag_out;

    logic [3:0]  state_a,    state_b;
    logic [15:0] req_addr_a, req_addr_b;
    logic [15:0] req_data_a, req_data_b;
    logic        req_wr_a,   req_wr_b;
    logic [15:0] mem_addr_a, mem_addr_b;
    logic        err_a,      err_b;
    logic [15:0] miss_count_a;
    logic [1:0]  miss_count_b;

    cache_ctrl_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .hit(hit), .valid(valid), .dirty(dirty),
        .tag_out(tag_out), .mem_stall(mem_stall), .state(state_a),
        .req_addr(req_addr_a), .req_data(req_data_a), .req_wr(req_wr_a),
        .mem_addr(mem_addr_a), .err(err_a), .miss_count(miss_count_a)
    );

    cache_ctrl_fsm #(.MISS_CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .hit(hit), .valid(valid), .dirty(dirty),
        .tag_out(tag_out), .mem_stall(mem_stall), .state(state_b),
        .req_addr(req_addr_b), .req_data(req_data_b), .req_wr(req_wr_b),
        .mem_addr(mem_addr_b), .err(err_b), .miss_count(miss_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ma;
        logic        er;
        logic [15:0] mc;
        logic [1:0]  mc2;
        logic [15:0] ra;
        logic [15:0] rdt;
        logic        rw;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    // Expected latched request, updated by the stimulus after each miss.
    logic [15:0] x_ra, x_rdt;
    logic        x_rw;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare every falling edge that has an expectation queued.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("state",      {12'd0, state_a},      {12'd0, e.st});
                chk("mem_addr",   mem_addr_a,            e.ma);
                chk("err",        {15'd0, err_a},        {15'd0, e.er});
                chk("miss_count", miss_count_a,          e.mc);
                chk("req_addr",   req_addr_a,            e.ra);
                chk("req_data",   req_data_a,            e.rdt);
                chk("req_wr",     {15'd0, req_wr_a},     {15'd0, e.rw});
                chk("state_w2",   {12'd0, state_b},      {12'd0, e.st});
                chk("mem_addr_w2", mem_addr_b,           e.ma);
                chk("err_w2",     {15'd0, err_b},        {15'd0, e.er});
                chk("miss_count_w2", {14'd0, miss_count_b}, {14'd0, e.mc2});
                chk("req_addr_w2", req_addr_b,           e.ra);
                chk("req_data_w2", req_data_b,           e.rdt);
                chk("req_wr_w2",  {15'd0, req_wr_b},     {15'd0, e.rw});
            end
        end
    end

    // Push the expectation for the current cycle, then advance to just after
    // the next rising edge where the next cycle's inputs are driven.
    task automatic step(input logic [3:0] st, input logic [15:0] ma, input logic er,
                        input logic [15:0] mc, input logic [1:0] mc2);
        exp_t e;
        e.st = st; e.ma = ma; e.er = er; e.mc = mc; e.mc2 = mc2;
        e.ra = x_ra; e.rdt = x_rdt; e.rw = x_rw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0; hit = 1'b0;
        valid = 1'b0; dirty = 1'b0; tag_out = 5'h0; mem_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        x_ra = 16'h0; x_rdt = 16'h0; x_rw = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);
        rst_n = 1'b1;
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);

        // Read hit: no transition, counter unchanged
        rd = 1'b1; addr = 16'h1234; hit = 1'b1; valid = 1'b1;
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);

        // Clean read miss
        addr = 16'h1A46; hit = 1'b0; valid = 1'b0; data_in = 16'h1111;
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);
        x_ra = 16'h1A46; x_rdt = 16'h1111; x_rw = 1'b0;
        // Conflicting request outside IDLE must be ignored (no err, no latch)
        rd = 1'b1; wr = 1'b1; addr = 16'hFFFF; data_in = 16'hFFFF;
        step(4'h5, 16'h1A40, 1'b0, 16'd1, 2'd1);
        step(4'h6, 16'h1A42, 1'b0, 16'd1, 2'd1);
        step(4'h7, 16'h1A44, 1'b0, 16'd1, 2'd1);
        step(4'h8, 16'h1A46, 1'b0, 16'd1, 2'd1);
        step(4'h9, 16'h1A46, 1'b0, 16'd1, 2'd1);
        step(4'hA, 16'h1A46, 1'b0, 16'd1, 2'd1);
        step(4'hB, 16'h1A46, 1'b0, 16'd1, 2'd1);
        step(4'hC, 16'h1A46, 1'b0, 16'd1, 2'd1);
        // Back in IDLE with rd&wr: err, stay, latch nothing
        step(4'h0, 16'h1A46, 1'b1, 16'd1, 2'd1);
        step(4'h0, 16'h1A46, 1'b1, 16'd1, 2'd1);

        // Dirty write miss
        idle_inputs();
        wr = 1'b1; addr = 16'h1A46; valid = 1'b1; dirty = 1'b1;
        tag_out = 5'h1F; data_in = 16'hBEEF;
        step(4'h0, 16'h1A46, 1'b0, 16'd1, 2'd1);
        x_ra = 16'h1A46; x_rdt = 16'hBEEF; x_rw = 1'b1;
        idle_inputs();
        step(4'h1, 16'hFA40, 1'b0, 16'd2, 2'd2);
        step(4'h2, 16'hFA42, 1'b0, 16'd2, 2'd2);
        step(4'h3, 16'hFA44, 1'b0, 16'd2, 2'd2);
        step(4'h4, 16'hFA46, 1'b0, 16'd2, 2'd2);
        step(4'h5, 16'h1A40, 1'b0, 16'd2, 2'd2);
        step(4'h6, 16'h1A42, 1'b0, 16'd2, 2'd2);
        step(4'h7, 16'h1A44, 1'b0, 16'd2, 2'd2);
        step(4'h8, 16'h1A46, 1'b0, 16'd2, 2'd2);
        step(4'h9, 16'h1A46, 1'b0, 16'd2, 2'd2);
        step(4'hA, 16'h1A46, 1'b0, 16'd2, 2'd2);
        step(4'hB, 16'h1A46, 1'b0, 16'd2, 2'd2);
        step(4'hC, 16'h1A46, 1'b0, 16'd2, 2'd2);

        // New dirty miss in the IDLE cycle right after DONE, stalled in WB1
        wr = 1'b1; addr = 16'h5A4C; valid = 1'b1; dirty = 1'b1;
        tag_out = 5'h0A; data_in = 16'h1234;
        step(4'h0, 16'h1A46, 1'b0, 16'd2, 2'd2);
        x_ra = 16'h5A4C; x_rdt = 16'h1234; x_rw = 1'b1;
        idle_inputs();
        step(4'h1, 16'h5248, 1'b0, 16'd3, 2'd3);
        mem_stall = 1'b1;
        step(4'h2, 16'h524A, 1'b0, 16'd3, 2'd3);
        step(4'h2, 16'h524A, 1'b0, 16'd3, 2'd3);
        step(4'h2, 16'h524A, 1'b0, 16'd3, 2'd3);
        mem_stall = 1'b0;
        step(4'h2, 16'h524A, 1'b0, 16'd3, 2'd3);
        step(4'h3, 16'h524C, 1'b0, 16'd3, 2'd3);
        step(4'h4, 16'h524E, 1'b0, 16'd3, 2'd3);
        step(4'h5, 16'h5A48, 1'b0, 16'd3, 2'd3);
        step(4'h6, 16'h5A4A, 1'b0, 16'd3, 2'd3);
        step(4'h7, 16'h5A4C, 1'b0, 16'd3, 2'd3);
        step(4'h8, 16'h5A4E, 1'b0, 16'd3, 2'd3);
        step(4'h9, 16'h5A4C, 1'b0, 16'd3, 2'd3);
        step(4'hA, 16'h5A4C, 1'b0, 16'd3, 2'd3);
        // Stall is ignored in UPD, DONE and IDLE
        mem_stall = 1'b1;
        step(4'hB, 16'h5A4C, 1'b0, 16'd3, 2'd3);
        step(4'hC, 16'h5A4C, 1'b0, 16'd3, 2'd3);

        // Fourth miss: 2-bit counter stays saturated at 3
        rd = 1'b1; addr = 16'h0002; data_in = 16'h2222; valid = 1'b0;
        step(4'h0, 16'h5A4C, 1'b0, 16'd3, 2'd3);
        x_ra = 16'h0002; x_rdt = 16'h2222; x_rw = 1'b0;
        idle_inputs();
        step(4'h5, 16'h0000, 1'b0, 16'd4, 2'd3);
        step(4'h6, 16'h0002, 1'b0, 16'd4, 2'd3);

        // Now in RD2: asynchronous reset clears everything before any edge
        rst_n = 1'b0;
        x_ra = 16'h0; x_rdt = 16'h0; x_rw = 1'b0;
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);
        rst_n = 1'b1;
        step(4'h0, 16'h0000, 1'b0, 16'd0, 2'd0);

        // Every queued expectation must have been consumed by the monitor
        @(negedge clk);
        #1;
        chk("queue_drained", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Miss-sequencing controller for the direct-mapped cache. It produces the 4-bit controller state consumed by the cache/memory signal decoder, and latches the CPU request for the duration of a miss. It forms the four-bank memory address for the write-back and refill bursts and counts misses. It sits between the CPU memory port, the cache tag/data arrays and the four-banked main memory.

## Interface
- MISS_CNT_W, 16, width of the saturating miss counter.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd  in  1  CPU read request.
- wr  in  1  CPU write request.
- addr  in  16  CPU byte address: tag [15:11], index [10:3], word offset [2:1], byte [0].
- data_in  in  16  CPU write data.
- hit  in  1  cache tag match for the current lookup.
- valid  in  1  valid bit of the indexed line.
- dirty  in  1  dirty bit of the indexed line.
- tag_out  in  5  tag stored in the indexed line.
- mem_stall  in  1  memory bank conflict; freezes the burst.
- state  out  4  controller state code.
- req_addr  out  16  latched request address.
- req_data  out  16  latched write data.
- req_wr  out  1  latched request is a write.
- mem_addr  out  16  address to main memory.
- err  out  1  rd and wr asserted together in IDLE.
- miss_count  out  MISS_CNT_W  saturating count of misses.

## Operation
- States: IDLE 0000, WB0–WB3 0001–0100, RD0–RD3 0101–1000, FILL2 1001, FILL3 1010, UPD 1011, DONE 1100. Codes 1101–1111 are illegal and go to IDLE on the next edge.
- IDLE:
  - rd^wr with hit&valid: stay in IDLE. The hit completes in the same cycle.
  - rd^wr with a miss and valid&dirty: go to WB0.
  - rd^wr with a miss and the line clean or invalid: go to RD0.
  - No request: stay in IDLE.
  - rd&wr: err=1 for that cycle. No transition, no latch.
- On a miss in IDLE, latch addr→req_addr, data_in→req_data, wr→req_wr and tag_out→victim tag (internal). Increment miss_count, saturating at all-ones.
- Latched values hold from the edge leaving IDLE until the edge returning to IDLE. Request inputs are ignored outside IDLE.
- WB0→WB1→WB2→WB3→RD0: writes back words 0..3.
- RD0→RD1→RD2→RD3→FILL2→FILL3→UPD→DONE→IDLE: reads words 0..3. Each read returns two cycles later and is written to the cache in RD2, RD3, FILL2, FILL3 respectively.
- UPD: compare-mode access that sets tag/valid and applies req_data if req_wr. DONE signals completion.
- mem_stall=1 in WB0..FILL3: state holds; the memory pipeline holds with it. mem_stall is ignored in IDLE, UPD and DONE.
- mem_addr:
  - WBn: {victim tag, req_addr[10:3], n[1:0], 1'b0}.
  - RDn: {req_addr[15:3], n[1:0], 1'b0}.
  - All other states: req_addr.
- err is combinational from rd, wr and state==IDLE.

## Timing
- Reset: state=0000, req_addr=0, req_data=0, req_wr=0, victim tag=0, miss_count=0, err=0, mem_addr=0.
- Clean miss detected in IDLE at cycle 0: RD0 at cycle 1 … DONE at cycle 8, IDLE at cycle 9.
- Dirty miss: DONE at cycle 12, IDLE at cycle 13.
- Each stall cycle adds one cycle of latency.
- A new request is accepted in the IDLE cycle immediately after DONE.
- Reset mid-burst returns the FSM to IDLE asynchronously. The partially filled line is not repaired by this block.
- miss_count at all-ones stays at all-ones on further misses.

## Test plan
- **Reset:** rst_n=0 mid-RD2 → state=0000 immediately; req_addr=0, miss_count=0.
- **Read hit:** rd=1, hit=1, valid=1 in IDLE → state stays 0000; miss_count unchanged.
- **Clean read miss:** addr=0x1A46, valid=0 → states 0101,0110,0111,1000,1001,1010,1011,1100,0000 on successive cycles; mem_addr 0x1A40, 0x1A42, 0x1A44, 0x1A46 in RD0–RD3; miss_count=1.
- **Dirty write miss:** addr=0x1A46, valid=1, dirty=1, tag_out=5'h1F, data_in=0xBEEF → WB0–WB3 mem_addr 0xFA40, 0xFA42, 0xFA44, 0xFA46; then the refill sequence; req_data=0xBEEF and req_wr=1 through UPD; DONE at cycle 12.
- **Stall:** mem_stall=1 for 3 cycles in WB1 → state holds 0010 for those cycles; DONE at cycle 15.
- **Error and saturation:** rd=wr=1 in IDLE → err=1, state 0000, nothing latched. With MISS_CNT_W=2, four misses → miss_count stays 3.
